// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The loader FSM states and stream/word geometry live here.
package boot_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into little-endian words and keeps a running XOR of all
// bytes taken since the last clear.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_next_o,
    output logic              word_done_o,
    output logic [BYTE_W-1:0] csum_o
);

    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        word_next_o = word_q;
        case (byte_idx_q)
            2'd0:    word_next_o[7:0]   = byte_i;
            2'd1:    word_next_o[15:8]  = byte_i;
            2'd2:    word_next_o[23:16] = byte_i;
            default: word_next_o[31:24] = byte_i;
        endcase

        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        if (clear_i) begin
            byte_idx_d = '0;
            word_d     = '0;
            csum_d     = '0;
        end else if (byte_en_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = word_next_o;
            csum_d     = csum_q ^ byte_i;
        end
    end

    assign word_done_o = byte_en_i && !clear_i && (byte_idx_q == 2'd3);
    assign csum_o      = csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked byte image into core memory through the
// Ext_* write port and holds the core in reset until the load is verified.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              Ext_MemWrite,
    output logic [31:0]       Ext_DataAdr,
    output logic [31:0]       Ext_WriteData,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  words_written
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              xfer;
    logic [CNT_W-1:0]  n_rx;
    logic [WORD_W-1:0] word_next;
    logic              word_done;
    logic [BYTE_W-1:0] csum;

    assign xfer = rx_valid && rx_ready;
    assign n_rx = {rx_data, cnt_lo_q};

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    ((state_q == StHdr1) && xfer),
        .byte_en_i  ((state_q == StData) && xfer),
        .byte_i     (rx_data),
        .word_next_o(word_next),
        .word_done_o(word_done),
        .csum_o     (csum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHdr0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHdr0:  if (xfer) state_d = StHdr1;
            StHdr1: begin
                if (xfer) begin
                    if ({16'd0, n_rx} > MAX_WORDS) state_d = StErr;
                    else if (n_rx == '0)           state_d = StCsum;
                    else                           state_d = StData;
                end
            end
            StData:  if (word_done) state_d = StWrite;
            StWrite: state_d = (word_idx_q + 16'd1 == cnt_q) ? StCsum : StData;
            StCsum:  if (xfer) state_d = (rx_data == csum) ? StDone : StErr;
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StHdr0;
        endcase
    end

    always_comb begin
        rx_ready  = !reset && ((state_q == StHdr0) || (state_q == StHdr1) ||
                               (state_q == StData) || (state_q == StCsum));
        cpu_reset = (state_q != StDone);
        load_done = (state_q == StDone);
        load_err  = (state_q == StErr);
    end

    // Ext_* are registered on the fourth-byte edge, so the pulse lines up with WRITE.
    always_comb begin
        cnt_lo_d    = ((state_q == StHdr0) && xfer) ? rx_data : cnt_lo_q;
        cnt_d       = ((state_q == StHdr1) && xfer) ? n_rx : cnt_q;
        word_idx_d  = (state_q == StWrite) ? word_idx_q + 16'd1 : word_idx_q;
        mem_write_d = word_done;
        adr_d       = word_done ? BASE_ADDR + {14'd0, word_idx_q, 2'b00} : adr_q;
        wdata_d     = word_done ? word_next : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lo_q    <= '0;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            mem_write_q <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
        end else begin
            cnt_lo_q    <= cnt_lo_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            mem_write_q <= mem_write_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign Ext_MemWrite  = mem_write_q;
    assign Ext_DataAdr   = adr_q;
    assign Ext_WriteData = wdata_q;
    assign words_written = word_idx_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream loader for the single-cycle RISC-V core. It receives a program image as a byte stream over a valid/ready handshake and assembles the bytes into little-endian 32-bit words. Each word is written through the core's external memory port (Ext_MemWrite / Ext_DataAdr / Ext_WriteData), and the core is held in reset until a checksum-verified load completes. It replaces the bench's static tie-off of the Ext_* inputs and lets the directed instruction programs be loaded at run time.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, largest accepted word count (1..65535).

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; one clock, no other clock domain.
- rx_data  in  8  image byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- Ext_MemWrite  out  1  one-cycle word write strobe into core memory.
- Ext_DataAdr  out  32  write byte address.
- Ext_WriteData  out  32  write data.
- cpu_reset  out  1  drives core `reset`.
- load_done  out  1  image written and checksum matched (sticky).
- load_err  out  1  count or checksum failure (sticky).
- words_written  out  16  number of completed word writes.

## Operation
- **Stream format:** CNT_LO, CNT_HI (N, 16-bit little-endian), then 4N payload bytes, then CSUM.
  - CSUM is the XOR of all payload bytes; header bytes are excluded.
- **Byte transfer:** a byte transfers on an edge where rx_valid && rx_ready.
  - rx_ready is a Moore decode: high only in HDR0, HDR1, DATA and CSUM, and forced to 0 while reset is high.
- **FSM states:**
  - HDR0: transfer → HDR1, latch CNT_LO.
  - HDR1: transfer → latch CNT_HI. If N > MAX_WORDS → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: each transfer places the byte in lane byte_idx (bits 8k+7:8k) and XORs it into the running checksum. The transfer with byte_idx==3 → WRITE.
  - WRITE: exactly one cycle. Ext_MemWrite=1, Ext_DataAdr=BASE_ADDR+4*word_idx, Ext_WriteData=assembled word. Then word_idx++ and words_written++; if the new word_idx==N → CSUM, else → DATA.
  - CSUM: transfer → DONE if the byte equals the running XOR, else → ERR.
  - DONE: cpu_reset=0, load_done=1. Terminal until reset.
  - ERR: cpu_reset=1, load_err=1. Terminal until reset.
- **Address arithmetic:** 32-bit, wraps modulo 2^32.
- **Bus outputs outside WRITE:** Ext_DataAdr and Ext_WriteData hold their last values, while Ext_MemWrite=0.
- **Reset values:** state=HDR0, rx_ready=0, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, cpu_reset=1, load_done=0, load_err=0, words_written=0, checksum=0, byte_idx=0, word_idx=0.
- **Reset mid-load:** returns to HDR0 and discards the partial word. Memory already written is not rolled back.
- **ERR after writes:** words already written remain in memory; the core stays in reset.
- **Bytes arriving in WRITE, DONE or ERR:** ignored (rx_ready=0), never consumed.

## Timing
- Fourth byte of a word accepted at edge k → Ext_MemWrite high for the cycle k..k+1, and memory samples it at edge k+1.
- Peak throughput: 1 word per 5 cycles (4 transfers + 1 write cycle).
- CSUM accepted at edge m → DONE from edge m. In that cycle cpu_reset is already 0 and load_done is 1, so the core fetches PC=0 on edge m+1.
- An idle rx_valid does not time out; the loader waits indefinitely in any accepting state.

## Structure
- Package `boot_pkg`:
  - state enum (HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR);
  - CNT_W=16, BYTE_W=8, WORD_BYTES=4;
  - default BASE_ADDR.
- Sub-module `byte_word_packer`: byte_idx counter, lane insert, word-complete pulse and XOR accumulator. It is cleared by reset and by the HDR1 transfer.
- The top level holds the FSM, word_idx, the address adder and the Ext_* output registers.

## Test plan
- **Normal load:** N=2, payload 13 00 00 00 EF BE AD DE, CSUM 0x31.
  - Writes (0x0, 0x00000013) and (0x4, 0xDEADBEEF), each a single-cycle Ext_MemWrite pulse.
  - words_written=2, load_done=1, cpu_reset falls at the CSUM edge.
- **Bad checksum:** same stream with CSUM 0x30.
  - Both writes occur, then load_err=1, cpu_reset stays 1, load_done=0.
- **Empty image:** N=0, CSUM 0x00.
  - DONE with no Ext_MemWrite pulse; rx_ready=0 afterwards.
- **Oversize count:** MAX_WORDS=4, N=5.
  - ERR right after the HDR1 transfer; no write ever occurs and rx_ready stays 0.
- **Stall and gaps:** rx_valid held high continuously.
  - rx_ready=0 during each WRITE cycle and no byte is lost or duplicated.
  - Random rx_valid gaps still produce the correct words.
- **Reset mid-word:** reset pulsed after 2 payload bytes of word 0, then a full valid stream is sent.
  - All outputs return to their reset values; the new stream loads cleanly from BASE_ADDR and ends in DONE.
